// File: rtl/apb_reg_slave_if.sv
`default_nettype none
// ============================================================================
//  Module      : apb_reg_slave_if
//  Description : APB bus bundle between a requester and the register slave.
//                Clock and reset travel as plain ports beside this interface.
//  Revision    : 1.0 - initial release
// ============================================================================
interface apb_reg_slave_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    output prdata, pready, pslverr
  );
endinterface
`default_nettype wire

// File: rtl/apb_reg_slave.sv
`default_nettype none
// ============================================================================
//  Module      : apb_reg_slave
//  Description : APB register slave with four RW registers, a read-only ID
//                register and a committed-write counter, programmable wait
//                states, slave error reporting and optional write protection.
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_reg_slave #(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [31:0] ID_VALUE    = 32'h5245_4701
) (
  input  logic           pclk,
  input  logic           preset_n,
  input  logic           wprot_en,
  apb_reg_slave_if.slave apb
);

  // Wait counter is three bits wide; legal WAIT_CYCLES values are 0..7.
  localparam logic [2:0]  C_WAIT_INIT = 3'(WAIT_CYCLES);
  localparam logic [11:0] C_OFF_ID    = 12'h010;
  localparam logic [11:0] C_OFF_WCNT  = 12'h014;
  localparam logic [11:0] C_OFF_LAST  = 12'h014;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       wait_q, wait_d;
  logic [3:0][31:0] regs_q, regs_d;
  logic [31:0]      wcnt_q, wcnt_d;

  logic [11:0] w_offset;
  logic        w_misaligned;
  logic        w_unmapped;
  logic        w_ro_write;
  logic        w_prot_fault;
  logic        w_err;
  logic        w_complete;
  logic [31:0] w_rd_value;
  logic        w_unused;

  // Only the low 12 address bits and the privilege bit of pprot are decoded.
  assign w_unused = ^{apb.paddr[31:12], apb.pprot[2:1]};

  // Address decode and error qualification, evaluated in the completing cycle.
  assign w_offset     = apb.paddr[11:0];
  assign w_misaligned = |w_offset[1:0];
  assign w_unmapped   = (w_offset > C_OFF_LAST);
  assign w_ro_write   = apb.pwrite && ((w_offset == C_OFF_ID) || (w_offset == C_OFF_WCNT));
  assign w_prot_fault = apb.pwrite && wprot_en && !apb.pprot[0];
  assign w_err        = w_misaligned || w_unmapped || w_ro_write || w_prot_fault;

  // A transfer completes once the wait budget is exhausted in the access phase.
  assign w_complete = (state_q == ST_ACCESS) && (wait_q == 3'd0) && apb.psel && apb.penable;

  // Read mux over the mapped word offsets; unmapped words are masked by w_err.
  always_comb begin
    w_rd_value = '0;
    case (w_offset[4:2])
      3'd0, 3'd1, 3'd2, 3'd3: w_rd_value = regs_q[w_offset[3:2]];
      3'd4:                   w_rd_value = ID_VALUE;
      3'd5:                   w_rd_value = wcnt_q;
      default:                w_rd_value = '0;
    endcase
  end

  // Response outputs are qualified by completion so they stay 0 outside it.
  assign apb.pready  = w_complete;
  assign apb.pslverr = w_complete && w_err;
  assign apb.prdata  = (w_complete && !apb.pwrite && !w_err) ? w_rd_value : 32'h0;

  // Next-state computation for the handshake FSM, wait counter and registers.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    regs_d  = regs_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      ST_IDLE: begin
        // penable without a preceding setup phase is ignored here.
        if (apb.psel && !apb.penable) begin
          state_d = ST_ACCESS;
          wait_d  = C_WAIT_INIT;
        end
      end
      ST_ACCESS: begin
        if (!apb.psel) begin
          // Abort: drop back with nothing committed.
          state_d = ST_IDLE;
          wait_d  = 3'd0;
        end else if (wait_q != 3'd0) begin
          wait_d = wait_q - 3'd1;
        end else if (apb.penable) begin
          state_d = ST_IDLE;
          if (apb.pwrite && !w_err) begin
            for (int i = 0; i < 4; i++) begin
              if (apb.pstrb[i]) begin
                regs_d[w_offset[3:2]][8*i +: 8] = apb.pwdata[8*i +: 8];
              end
            end
            // A zero strobe still counts as a committed write.
            wcnt_d = wcnt_q + 32'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        wait_d  = 3'd0;
      end
    endcase
  end

  // State and register flops with synchronous active-low reset.
  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      state_q <= ST_IDLE;
      wait_q  <= 3'd0;
      regs_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      regs_q  <= regs_d;
      wcnt_q  <= wcnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_reg_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_reg_slave
//  Description : Self-checking bench for apb_reg_slave. Two instances
//                (WAIT_CYCLES 0 and 3) share one stimulus bus selected by dsel;
//                results are checked against a behavioural register model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_reg_slave;

  localparam logic [31:0] C_ID = 32'h5245_4701;

  logic        pclk;
  logic        preset_n;
  logic        wprot_en;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  bit          dsel;

  logic        pready, pslverr;
  logic [31:0] prdata;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: register contents and write count per instance.
  logic [31:0] m_regs [2][4];
  logic [31:0] m_wcnt [2];

  apb_reg_slave_if bus0 ();
  apb_reg_slave_if bus3 ();

  assign bus0.psel    = psel && (dsel == 1'b0);
  assign bus3.psel    = psel && (dsel == 1'b1);
  assign bus0.penable = penable;
  assign bus3.penable = penable;
  assign bus0.pwrite  = pwrite;
  assign bus3.pwrite  = pwrite;
  assign bus0.paddr   = paddr;
  assign bus3.paddr   = paddr;
  assign bus0.pwdata  = pwdata;
  assign bus3.pwdata  = pwdata;
  assign bus0.pstrb   = pstrb;
  assign bus3.pstrb   = pstrb;
  assign bus0.pprot   = pprot;
  assign bus3.pprot   = pprot;

  assign pready  = dsel ? bus3.pready  : bus0.pready;
  assign pslverr = dsel ? bus3.pslverr : bus0.pslverr;
  assign prdata  = dsel ? bus3.prdata  : bus0.prdata;

  apb_reg_slave #(.WAIT_CYCLES(0), .ID_VALUE(C_ID)) u_dut0 (
    .pclk     (pclk),
    .preset_n (preset_n),
    .wprot_en (wprot_en),
    .apb      (bus0)
  );

  apb_reg_slave #(.WAIT_CYCLES(3), .ID_VALUE(C_ID)) u_dut3 (
    .pclk     (pclk),
    .preset_n (preset_n),
    .wprot_en (wprot_en),
    .apb      (bus3)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog expired");
  end

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 4; k++) m_regs[d][k] = 32'h0;
      m_wcnt[d] = 32'h0;
    end
  endtask

  // Expected outcome of one completed transfer, derived from the register map.
  function automatic void model_access(input int d, input bit wr, input logic [31:0] addr,
                                       input logic [31:0] data, input logic [3:0] strb,
                                       input logic [2:0] prot, input bit wp,
                                       output logic [31:0] erd, output bit eerr);
    int off;
    off  = int'(addr[11:0]);
    eerr = (off % 4 != 0) || (off > 'h14) || (wr && (off == 'h10 || off == 'h14))
           || (wr && wp && !prot[0]);
    erd  = 32'h0;
    if (!eerr) begin
      if (wr) begin
        for (int i = 0; i < 4; i++)
          if (strb[i]) m_regs[d][off / 4][8*i +: 8] = data[8*i +: 8];
        m_wcnt[d] = m_wcnt[d] + 32'd1;
      end else if (off < 'h10) begin
        erd = m_regs[d][off / 4];
      end else if (off == 'h10) begin
        erd = C_ID;
      end else begin
        erd = m_wcnt[d];
      end
    end
  endfunction

  task automatic idle(input int n);
    psel = 1'b0; penable = 1'b0;
    repeat (n) begin @(posedge pclk); #1; end
  endtask

  // Drives one transfer starting now (1 time unit after an edge) and returns
  // the response. Leaves psel high so a following call is back-to-back.
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input logic [2:0] prot,
                      output logic [31:0] rd, output bit er, output int waits, output bit leak);
    bit done;
    done = 1'b0; rd = 32'h0; er = 1'b0; waits = 0; leak = 1'b0;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
    pwdata = data; pstrb = strb; pprot = prot;
    @(posedge pclk); #1;
    penable = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge pclk);
      if (pready === 1'b1) begin
        rd = prdata; er = pslverr; done = 1'b1;
      end else begin
        waits++;
        if (pslverr !== 1'b0 || prdata !== 32'h0) leak = 1'b1;
      end
      @(posedge pclk); #1;
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL xfer_timeout addr=%h: pready not seen, required within 20 cycles", addr);
    end
  endtask

  // Transfer plus model prediction in one step.
  task automatic run(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                     input logic [3:0] strb, input logic [2:0] prot,
                     output logic [31:0] rd, output bit er, output int waits, output bit leak,
                     output logic [31:0] erd, output bit eerr);
    model_access(int'(dsel), wr, addr, data, strb, prot, wprot_en, erd, eerr);
    xfer(wr, addr, data, strb, prot, rd, er, waits, leak);
  endtask

  task automatic test_reset();
    logic [31:0] rd, erd; bit er, eerr, lk; int w;
    preset_n = 1'b0; psel = 1'b0; penable = 1'b0; wprot_en = 1'b0; dsel = 1'b0;
    pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
    repeat (3) @(posedge pclk);
    #1; model_reset();
    n_tests++;
    if ({bus0.pready, bus0.pslverr, bus0.prdata, bus3.pready, bus3.pslverr, bus3.prdata} !== 66'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy0=%b err0=%b rd0=%h rdy3=%b err3=%b rd3=%h, required all 0",
               bus0.pready, bus0.pslverr, bus0.prdata, bus3.pready, bus3.pslverr, bus3.prdata);
    end
    preset_n = 1'b1;
    @(posedge pclk); #1;
    for (int k = 0; k < 6; k++) begin
      run(1'b0, 32'(4 * k), 32'h0, 4'h0, 3'b000, rd, er, w, lk, erd, eerr);
      n_tests++;
      if (rd !== erd || er !== 1'b0 || (k < 4 || k == 5) && rd !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_read off=%h: got %h err=%b, required %h err=0", 4 * k, rd, er, erd);
      end
    end
    idle(1);
  endtask

  task automatic test_basic_w0();
    logic [31:0] rd, erd; bit er, eerr, lk; int w;
    dsel = 1'b0; wprot_en = 1'b0;
    run(1'b1, 32'h0, 32'hDEAD_BEEF, 4'hF, 3'b000, rd, er, w, lk, erd, eerr);
    n_tests++;
    if (er !== 1'b0 || w != 0) begin
      n_fail++; $display("FAIL basic_write: got err=%b waits=%0d, required err=0 waits=0", er, w);
    end
    idle(1);
    run(1'b0, 32'h0, 32'h0, 4'h0, 3'b000, rd, er, w, lk, erd, eerr);
    n_tests++;
    if (rd !== 32'hDEAD_BEEF || er !== 1'b0 || w != 0) begin
      n_fail++;
      $display("FAIL basic_read: got %h err=%b waits=%0d, required deadbeef err=0 waits=0", rd, er, w);
    end
    run(1'b0, 32'h14, 32'h0, 4'h0, 3'b000, rd, er, w, lk, erd, eerr);
    n_tests++;
    if (rd !== 32'd1 || er !== 1'b0) begin
      n_fail++; $display("FAIL basic_wcnt: got %h err=%b, required 00000001 err=0", rd, er);
    end
    idle(1);
  endtask

  task automatic test_strobe();
    logic [31:0] rd, erd; bit er, eerr, lk; int w;
    dsel = 1'b0;
    run(1'b1, 32'h4, 32'h1122_3344, 4'hF, 3'b000, rd, er, w, lk, erd, eerr);
    run(1'b1, 32'h4, 32'hAABB_CCDD, 4'b0101, 3'b000, rd, er, w, lk, erd, eerr);
    run(1'b1, 32'h4, 32'hFFFF_FFFF, 4'b0000, 3'b000, rd, er, w, lk, erd, eerr);
    run(1'b0, 32'h4, 32'h0, 4'h0, 3'b000, rd, er, w, lk, erd, eerr);
    n_tests++;
    if (rd !== 32'h11BB_33DD || er !== 1'b0) begin
      n_fail++; $display("FAIL strobe_merge: got %h err=%b, required 11bb33dd err=0", rd, er);
    end
    run(1'b0, 32'h14, 32'h0, 4'h0, 3'b000, rd, er, w, lk, erd, eerr);
    n_tests++;
    if (rd !== erd || rd !== 32'd4) begin
      n_fail++; $display("FAIL strobe_wcnt: got %h, required %h", rd, erd);
    end
    idle(2);
  endtask

  task automatic test_wait3();
    logic [31:0] rd, erd; bit er, eerr, lk; int w;
    dsel = 1'b1;
    run(1'b1, 32'h8, 32'h0BAD_F00D, 4'hF, 3'b000, rd, er, w, lk, erd, eerr);
    n_tests++;
    if (w != 3 || lk || er !== 1'b0) begin
      n_fail++; $display("FAIL wait3_write: got waits=%0d leak=%b err=%b, required waits=3 leak=0 err=0", w, lk, er);
    end
    run(1'b0, 32'h8, 32'h0, 4'h0, 3'b000, rd, er, w, lk, erd, eerr);
    n_tests++;
    if (w != 3 || lk || rd !== 32'h0BAD_F00D) begin
      n_fail++; $display("FAIL wait3_read: got waits=%0d leak=%b data=%h, required waits=3 leak=0 data=0badf00d", w, lk, rd);
    end
    idle(1);
  endtask

  task automatic test_errors();
    logic [31:0] rd, erd; bit er, eerr, lk; int w;
    bit          e_wr [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] e_ad [4] = '{32'h10, 32'h18, 32'h2, 32'h8};
    bit          e_wp [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    dsel = 1'b0; wprot_en = 1'b0;
    run(1'b1, 32'h8, 32'hCAFE_F00D, 4'hF, 3'b000, rd, er, w, lk, erd, eerr);
    for (int k = 0; k < 4; k++) begin
      wprot_en = e_wp[k];
      run(e_wr[k], e_ad[k], 32'h5555_AAAA, 4'hF, 3'b000, rd, er, w, lk, erd, eerr);
      n_tests++;
      if (er !== 1'b1 || rd !== 32'h0 || w != 0) begin
        n_fail++;
        $display("FAIL error_case%0d addr=%h: got err=%b data=%h waits=%0d, required err=1 data=0 waits=0",
                 k, e_ad[k], er, rd, w);
      end
    end
    wprot_en = 1'b0;
    run(1'b0, 32'h8, 32'h0, 4'h0, 3'b000, rd, er, w, lk, erd, eerr);
    n_tests++;
    if (rd !== 32'hCAFE_F00D) begin
      n_fail++; $display("FAIL error_reg_kept: got %h, required cafef00d", rd);
    end
    run(1'b0, 32'h14, 32'h0, 4'h0, 3'b000, rd, er, w, lk, erd, eerr);
    n_tests++;
    if (rd !== erd || rd !== 32'd5) begin
      n_fail++; $display("FAIL error_wcnt_kept: got %h, required %h", rd, erd);
    end
    wprot_en = 1'b1;
    run(1'b1, 32'h8, 32'h1234_5678, 4'hF, 3'b001, rd, er, w, lk, erd, eerr);
    n_tests++;
    if (er !== 1'b0) begin
      n_fail++; $display("FAIL prot_priv_write: got err=%b, required 0", er);
    end
    run(1'b0, 32'h8, 32'h0, 4'h0, 3'b000, rd, er, w, lk, erd, eerr);
    n_tests++;
    if (rd !== 32'h1234_5678 || er !== 1'b0) begin
      n_fail++; $display("FAIL prot_priv_read: got %h err=%b, required 12345678 err=0", rd, er);
    end
    wprot_en = 1'b0;
    idle(1);
  endtask

  task automatic test_idle_penable();
    bit seen;
    dsel = 1'b0; seen = 1'b0;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 32'h10;
    repeat (3) begin
      @(negedge pclk); if (pready !== 1'b0) seen = 1'b1;
      @(posedge pclk); #1;
    end
    n_tests++;
    if (seen) begin
      n_fail++; $display("FAIL idle_penable: got pready=1 without setup, required 0");
    end
    idle(1);
  endtask

  task automatic test_abort();
    logic [31:0] rd, erd; bit er, eerr, lk; int w; bit seen;
    dsel = 1'b1; wprot_en = 1'b0; seen = 1'b0;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'hC;
    pwdata = 32'h5A5A_5A5A; pstrb = 4'hF; pprot = 3'b001;
    @(posedge pclk); #1; penable = 1'b1;
    @(negedge pclk); if (pready !== 1'b0) seen = 1'b1;
    @(posedge pclk); #1; psel = 1'b0; penable = 1'b0;
    repeat (3) begin
      @(negedge pclk); if (pready !== 1'b0) seen = 1'b1;
      @(posedge pclk); #1;
    end
    n_tests++;
    if (seen) begin
      n_fail++; $display("FAIL abort_pready: got pready=1 during aborted transfer, required 0");
    end
    run(1'b0, 32'hC, 32'h0, 4'h0, 3'b000, rd, er, w, lk, erd, eerr);
    n_tests++;
    if (rd !== erd || w != 3 || er !== 1'b0) begin
      n_fail++; $display("FAIL abort_no_commit: got %h waits=%0d, required %h waits=3", rd, w, erd);
    end
    run(1'b0, 32'h14, 32'h0, 4'h0, 3'b000, rd, er, w, lk, erd, eerr);
    n_tests++;
    if (rd !== erd) begin
      n_fail++; $display("FAIL abort_wcnt: got %h, required %h", rd, erd);
    end
    idle(1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, erd; bit er, eerr, lk; int w; bit bad;
    for (int d = 0; d < 2; d++) begin
      dsel = d[0]; bad = 1'b0;
      for (int k = 0; k < 4; k++) begin
        run(1'b1, 32'(4 * k), $urandom(), 4'hF, 3'b000, rd, er, w, lk, erd, eerr);
        if (er !== eerr || w != 3 * d) bad = 1'b1;
      end
      for (int k = 0; k < 4; k++) begin
        run(1'b0, 32'(4 * k), 32'h0, 4'h0, 3'b000, rd, er, w, lk, erd, eerr);
        if (rd !== erd || er !== 1'b0 || w != 3 * d) bad = 1'b1;
      end
      n_tests++;
      if (bad) begin
        n_fail++; $display("FAIL back_to_back dut%0d: got data/latency mismatch, required model data and waits=%0d", d, 3 * d);
      end
      idle(1);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, erd; bit er, eerr, lk; int w; bit bad;
    dsel = 1'b1; wprot_en = 1'b0;
    run(1'b1, 32'h0, 32'h7777_8888, 4'hF, 3'b000, rd, er, w, lk, erd, eerr);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h4;
    pwdata = 32'h9999_AAAA; pstrb = 4'hF; pprot = 3'b000;
    @(posedge pclk); #1; penable = 1'b1;
    @(posedge pclk); #1; preset_n = 1'b0;
    @(posedge pclk); #1;
    n_tests++;
    if ({bus0.pready, bus0.pslverr, bus0.prdata, bus3.pready, bus3.pslverr, bus3.prdata} !== 66'h0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got rdy3=%b err3=%b rd3=%h, required all 0",
               bus3.pready, bus3.pslverr, bus3.prdata);
    end
    @(posedge pclk); #1;
    preset_n = 1'b1; psel = 1'b0; penable = 1'b0;
    model_reset();
    @(posedge pclk); #1;
    run(1'b0, 32'h10, 32'h0, 4'h0, 3'b000, rd, er, w, lk, erd, eerr);
    n_tests++;
    if (rd !== 32'h5245_4701 || w != 3 || er !== 1'b0) begin
      n_fail++; $display("FAIL midreset_id: got %h waits=%0d, required 52454701 waits=3", rd, w);
    end
    bad = 1'b0;
    for (int d = 0; d < 2; d++) begin
      dsel = d[0];
      for (int k = 0; k < 6; k++) begin
        if (k == 4) continue;
        run(1'b0, 32'(4 * k), 32'h0, 4'h0, 3'b000, rd, er, w, lk, erd, eerr);
        if (rd !== 32'h0 || er !== 1'b0) bad = 1'b1;
      end
    end
    n_tests++;
    if (bad) begin
      n_fail++; $display("FAIL midreset_cleared: got nonzero REG/WCNT after reset, required 0");
    end
    idle(1);
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, a, dat; bit er, eerr, lk, wr; int w; logic [3:0] st; logic [2:0] pr;
    for (int n = 0; n < 200; n++) begin
      dsel = $urandom_range(0, 1);
      a = $urandom();
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: a[11:0] = 12'(4 * $urandom_range(0, 5));
        6:                a[11:0] = 12'h018;
        7:                a[11:0] = 12'(4 * $urandom_range(0, 5) + $urandom_range(1, 3));
        8:                a[11:0] = 12'($urandom());
        default:          a[11:0] = 12'h010;
      endcase
      wr  = $urandom_range(0, 1);
      dat = $urandom();
      st  = 4'($urandom_range(0, 15));
      pr  = 3'($urandom_range(0, 7));
      wprot_en = ($urandom_range(0, 3) == 0);
      run(wr, a, dat, st, pr, rd, er, w, lk, erd, eerr);
      n_tests++;
      if (er !== eerr || rd !== erd || w != 3 * int'(dsel) || lk) begin
        n_fail++;
        $display("FAIL random#%0d dut%0d wr=%b addr=%h: got data=%h err=%b waits=%0d leak=%b, required data=%h err=%b waits=%0d leak=0",
                 n, dsel, wr, a, rd, er, w, lk, erd, eerr, 3 * int'(dsel));
      end
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    wprot_en = 1'b0;
    idle(1);
  endtask

  initial begin
    test_reset();
    test_basic_w0();
    test_strobe();
    test_wait3();
    test_errors();
    test_idle_penable();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apb_reg_slave.md
APB_REG_SLAVE -- requirements
Module: apb_reg_slave

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 0, giving the number of wait states per transfer, legal range 0..7.
REQ-002 The block SHALL have parameter ID_VALUE, default 32'h5245_4701, giving the read-only ID register content.
REQ-003 Port pclk SHALL be a 1-bit input: the single clock, rising-edge active.
REQ-004 Port preset_n SHALL be a 1-bit input: reset, synchronous, active-low.
REQ-005 Ports psel, penable and pwrite SHALL each be a 1-bit input: APB select, enable and write-direction.
REQ-006 Port paddr SHALL be a 32-bit input: byte address; only paddr[11:0] is decoded and upper bits are ignored.
REQ-007 Port pwdata SHALL be a 32-bit input: write data.
REQ-008 Port pstrb SHALL be a 4-bit input: write byte strobes, with bit i enabling pwdata[8i+7:8i].
REQ-009 Port pprot SHALL be a 3-bit input: protection type, where bit 0 = privileged.
REQ-010 Port wprot_en SHALL be a 1-bit input: write-protect enable.
REQ-011 Port prdata SHALL be a 32-bit output: read data.
REQ-012 Port pready SHALL be a 1-bit output: transfer complete.
REQ-013 Port pslverr SHALL be a 1-bit output: transfer error.

Function
REQ-014 The register map SHALL be: 0x000..0x00C = REG0..REG3, 32-bit RW; 0x010 = ID (RO, ID_VALUE); 0x014 = WCNT (RO, 32-bit count of committed writes).
REQ-015 The FSM SHALL have states IDLE and ACCESS.
REQ-016 In IDLE, psel=1 with penable=0 (setup phase) SHALL move the FSM to ACCESS and load the 3-bit wait counter with WAIT_CYCLES.
REQ-017 In ACCESS with psel=1 and counter != 0, the counter SHALL decrement each cycle with pready=0.
REQ-018 pready SHALL be 1 exactly when state=ACCESS, counter=0 and psel=penable=1, giving access latency WAIT_CYCLES+1 cycles after setup.
REQ-019 The clock edge with psel&penable&pready=1 SHALL complete the transfer and return the FSM to IDLE; a following setup phase is accepted from IDLE on the next cycle, giving back-to-back transfers.
REQ-020 If psel falls while in ACCESS (abort), the FSM SHALL return to IDLE with no register update, no WCNT change and no pready pulse.
REQ-021 Error condition ERR SHALL be the OR of: paddr[1:0] != 0; offset unmapped (> 0x014); write to ID or WCNT; pwrite=1 and wprot_en=1 and pprot[0]=0.
REQ-022 pslverr SHALL equal ERR only while pready=1, and SHALL be 0 otherwise.
REQ-023 A write SHALL commit only on the completing edge and only when ERR=0; only bytes with pstrb[i]=1 are updated, and pstrb=4'b0000 commits nothing but still counts as a write.
REQ-024 WCNT SHALL increment by 1 on each committed error-free write, wrapping from 0xFFFF_FFFF to 0.
REQ-025 prdata SHALL carry the addressed register value while pready=1 for an error-free read, and SHALL be 32'h0 at all other times, including errored reads and writes.
REQ-026 Address, pwrite, pstrb, pprot and wprot_en SHALL be sampled during the completing cycle; changes earlier in the access phase have no effect other than being protocol violations.
REQ-027 penable=1 observed in IDLE without a preceding setup phase SHALL be ignored, with the FSM staying in IDLE and pready=0.

Reset
REQ-028 While preset_n=0 at a rising pclk edge, the block SHALL set state=IDLE, counter=0, REG0..REG3=0 and WCNT=0.
REQ-029 Outputs SHALL reset to pready=0, pslverr=0 and prdata=32'h0.
REQ-030 Reset asserted mid-transfer SHALL abort the transfer with no commit, and the first setup phase after release SHALL be accepted normally.

Verification
REQ-031 Bench SHALL cover: WAIT_CYCLES=0, write 0x000 <- 0xDEADBEEF with pstrb=4'hF, then read 0x000 -> pready in first access cycle, prdata=0xDEADBEEF, pslverr=0, WCNT=1.
REQ-032 Bench SHALL cover: REG1=0x11223344, write 0xAABBCCDD with pstrb=4'b0101 -> read 0x004 returns 0x11BB33DD.
REQ-033 Bench SHALL cover: WAIT_CYCLES=3, any access -> pready=0 for 3 access cycles and 1 in the 4th.
REQ-034 Bench SHALL cover errors: write 0x010, read 0x018, access 0x002, and write with wprot_en=1, pprot=3'b000 -> each gives pslverr=1 with pready, no register or WCNT change, prdata=0; the same write with pprot=3'b001 succeeds.
REQ-035 Bench SHALL cover: psel dropped in the 2nd wait cycle (WAIT_CYCLES=3) -> no commit, FSM returns to IDLE, next transfer completes normally.
REQ-036 Bench SHALL cover: preset_n=0 asserted during a wait state -> all outputs 0 next cycle, REG0..REG3=0, WCNT=0; read 0x010 after release -> 0x52454701.
